// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared types, segment encodings and helpers for the
//               multiplexed seven-segment display driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Converter FSM states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Active-low segment patterns, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    // 10^n, used at elaboration time for the overflow threshold
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    // BCD nibble to segments; codes above 9 cannot come from the converter
    // and fall back to the zero glyph
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_0;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_driver_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Iterative double-dabble binary-to-BCD converter. One bit per
//               cycle; DATA_W shift cycles then a single COMMIT cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_DIGITS = 4
) (
    input  logic                      clk_100mhz,
    input  logic                      reset,
    input  logic                      i_start,
    input  logic [DATA_W-1:0]         i_bin,
    output state_t                    o_state,
    output logic                      o_done,
    output logic [NUM_DIGITS*4-1:0]   o_bcd
);

    localparam int                c_bcd_w    = NUM_DIGITS * 4;
    localparam int                c_cnt_w    = $clog2(DATA_W);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DATA_W - 1);

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [DATA_W-1:0]    r_bin;
    logic [c_bcd_w-1:0]   r_bcd;
    logic [c_bcd_w-1:0]   w_bcd_adj;

    // Add-3 correction on every nibble that would exceed 9 after doubling
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Converter FSM: bits shifted out of the top nibble are dropped; the
    // caller flags that case separately as overflow
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bin   <= '0;
            r_bcd   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_bin   <= i_bin;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_bcd <= {w_bcd_adj[c_bcd_w-2:0], r_bin[DATA_W-1]};
                    r_bin <= {r_bin[DATA_W-2:0], 1'b0};
                    if (r_cnt == c_cnt_last) begin
                        r_state <= COMMIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_state = r_state;
    assign o_done  = (r_state == COMMIT);
    assign o_bcd   = r_bcd;

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Multiplexed common-anode seven-segment driver with valid/ready
//               load, sequential BCD conversion, leading-zero blanking,
//               overflow dashes and a freeze input.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int DATA_W        = 16,
    parameter int REFRESH_DIV   = 262144,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk_100mhz,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [DATA_W-1:0]     load_data,
    output logic                  load_ready,
    input  logic                  hold,
    output logic                  busy,
    output logic                  overflow,
    output logic [NUM_DIGITS-1:0] anode_n,
    output logic [6:0]            seg_n
);

    localparam int                    c_ref_w     = $clog2(REFRESH_DIV);
    localparam int                    c_idx_w     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_ref_w-1:0]    c_ref_last  = c_ref_w'(REFRESH_DIV - 1);
    localparam logic [c_idx_w-1:0]    c_idx_last  = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [63:0]           c_ovf_limit = pow10(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] c_anode_one = NUM_DIGITS'(1);

    state_t                          w_state;
    logic                            w_done;
    logic [NUM_DIGITS*4-1:0]         w_bcd;
    logic                            w_accept;
    logic                            r_ovf_next;
    logic [NUM_DIGITS-1:0][3:0]      r_display;
    logic [c_ref_w-1:0]              r_refresh;
    logic [c_idx_w-1:0]              r_digit_idx;
    logic                            w_zero_run;
    logic [NUM_DIGITS-1:0]           w_blank_mask;
    logic [6:0]                      w_seg_next;

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .i_start    (w_accept),
        .i_bin      (load_data),
        .o_state    (w_state),
        .o_done     (w_done),
        .o_bcd      (w_bcd)
    );

    // Ready only when the converter is idle and the display is not frozen;
    // forced low while reset is held
    assign load_ready = !reset && (w_state == IDLE) && !hold;
    assign w_accept   = load_valid && load_ready;
    assign busy       = (w_state != IDLE);

    // Capture overflow at acceptance, publish result and flag together at COMMIT
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            r_ovf_next <= 1'b0;
            r_display  <= '0;
            overflow   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ovf_next <= (64'(load_data) >= c_ovf_limit);
            end
            if (w_done) begin
                r_display <= w_bcd;
                overflow  <= r_ovf_next;
            end
        end
    end

    // Leading-zero mask: a digit is blankable when it and every digit above are 0
    always_comb begin
        w_zero_run   = 1'b1;
        w_blank_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_zero_run      = w_zero_run && (r_display[i] == 4'd0);
            w_blank_mask[i] = w_zero_run;
        end
    end

    // Segment pattern for the digit currently selected by the scanner
    always_comb begin
        if (overflow) begin
            w_seg_next = SEG_DASH;
        end else if ((BLANK_LEADING != 0) && w_blank_mask[r_digit_idx]) begin
            w_seg_next = SEG_BLANK;
        end else begin
            w_seg_next = seg_decode(r_display[r_digit_idx]);
        end
    end

    // Refresh counter, MSD-first digit scan and registered pin drivers
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            r_refresh   <= '0;
            r_digit_idx <= c_idx_last;
            anode_n     <= '1;
            seg_n       <= SEG_BLANK;
        end else begin
            anode_n <= ~(c_anode_one << r_digit_idx);
            seg_n   <= w_seg_next;
            if (r_refresh == c_ref_last) begin
                r_refresh   <= '0;
                r_digit_idx <= (r_digit_idx == '0) ? c_idx_last : r_digit_idx - 1'b1;
            end else begin
                r_refresh <= r_refresh + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Directed self-checking bench for seg7_scan_driver, with one
//               instance blanking leading zeros and one showing them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    logic        clk_100mhz = 1'b0;
    logic        reset      = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_data  = 16'd0;
    logic        hold       = 1'b0;

    logic        load_ready, busy, overflow;
    logic [3:0]  anode_n;
    logic [6:0]  seg_n;
    logic        nb_load_ready, nb_busy, nb_overflow;
    logic [3:0]  nb_anode_n;
    logic [6:0]  nb_seg_n;

    int total = 0;
    int bad   = 0;

    always #5 clk_100mhz = ~clk_100mhz;

    seg7_scan_driver #(.NUM_DIGITS(4), .DATA_W(16), .REFRESH_DIV(4), .BLANK_LEADING(1)) dut (
        .clk_100mhz (clk_100mhz), .reset (reset), .load_valid (load_valid),
        .load_data (load_data), .load_ready (load_ready), .hold (hold),
        .busy (busy), .overflow (overflow), .anode_n (anode_n), .seg_n (seg_n)
    );

    seg7_scan_driver #(.NUM_DIGITS(4), .DATA_W(16), .REFRESH_DIV(4), .BLANK_LEADING(0)) dut_nb (
        .clk_100mhz (clk_100mhz), .reset (reset), .load_valid (load_valid),
        .load_data (load_data), .load_ready (nb_load_ready), .hold (hold),
        .busy (nb_busy), .overflow (nb_overflow), .anode_n (nb_anode_n), .seg_n (nb_seg_n)
    );

    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_DASH  = 7'b1111110;
    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000, S7 = 7'b0001111, S9 = 7'b0000100;

    task automatic step();
        @(posedge clk_100mhz);
        #1;
    endtask

    function automatic int pos_of(input logic [3:0] a);
        case (a)
            4'b0111: return 3;
            4'b1011: return 2;
            4'b1101: return 1;
            4'b1110: return 0;
            default: return -1;
        endcase
    endfunction

    // One full refresh cycle on both instances; e*/n* are expected segments, MSD first
    task automatic check_scan(input string name,
                              input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0,
                              input logic [6:0] n3, input logic [6:0] n2,
                              input logic [6:0] n1, input logic [6:0] n0,
                              input logic ovf);
        logic [6:0] eb [4];
        logic [6:0] en [4];
        int p, q;
        eb[3] = e3; eb[2] = e2; eb[1] = e1; eb[0] = e0;
        en[3] = n3; en[2] = n2; en[1] = n1; en[0] = n0;
        total++;
        if (overflow !== ovf) begin
            bad++; $display("FAIL %s overflow: got %b want %b", name, overflow, ovf);
        end
        step();
        for (int c = 0; c < 16; c++) begin
            step();
            p = pos_of(anode_n);
            q = pos_of(nb_anode_n);
            total++;
            if (p < 0) begin
                bad++; $display("FAIL %s anode_n: got %b want one-hot-low", name, anode_n);
            end else if (seg_n !== eb[p]) begin
                bad++; $display("FAIL %s seg_n digit %0d: got %b want %b", name, p, seg_n, eb[p]);
            end
            total++;
            if (q < 0) begin
                bad++; $display("FAIL %s nb anode_n: got %b want one-hot-low", name, nb_anode_n);
            end else if (nb_seg_n !== en[q]) begin
                bad++; $display("FAIL %s nb seg_n digit %0d: got %b want %b", name, q, nb_seg_n, en[q]);
            end
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!load_ready && n < 60) begin
            step();
            n++;
        end
        if (!load_ready) begin
            total++; bad++;
            $display("FAIL %s wait_ready: got load_ready=0 want 1 within 60 cycles", name);
        end
    endtask

    // Accept one value, then measure how long busy stays high
    task automatic do_load(input logic [15:0] value, input string name);
        int n = 0;
        wait_ready(name);
        load_data  = value;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        load_data  = 16'($urandom);
        while (busy && n < 40) begin
            n++;
            step();
        end
        total++;
        if (n != 17) begin
            bad++; $display("FAIL %s busy_cycles: got %0d want 17", name, n);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_an [4];
        exp_an[0] = 4'b0111; exp_an[1] = 4'b1011; exp_an[2] = 4'b1101; exp_an[3] = 4'b1110;
        reset = 1'b1;
        step(); step();
        total++;
        if (anode_n !== 4'b1111 || nb_anode_n !== 4'b1111) begin
            bad++; $display("FAIL reset anode_n: got %b/%b want 1111", anode_n, nb_anode_n);
        end
        total++;
        if (seg_n !== S_BLANK || nb_seg_n !== S_BLANK) begin
            bad++; $display("FAIL reset seg_n: got %b/%b want 1111111", seg_n, nb_seg_n);
        end
        total++;
        if (load_ready !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL reset flags: got ready=%b busy=%b ovf=%b want 0 0 0",
                            load_ready, busy, overflow);
        end
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            total++;
            if (anode_n !== exp_an[k/4]) begin
                bad++; $display("FAIL reset_scan anode_n cyc %0d: got %b want %b", k, anode_n, exp_an[k/4]);
            end
            total++;
            if (seg_n !== ((k < 12) ? S_BLANK : S0)) begin
                bad++; $display("FAIL reset_scan seg_n cyc %0d: got %b want %b", k, seg_n,
                                (k < 12) ? S_BLANK : S0);
            end
            total++;
            if (nb_seg_n !== S0) begin
                bad++; $display("FAIL reset_scan nb seg_n cyc %0d: got %b want %b", k, nb_seg_n, S0);
            end
        end
        total++;
        if (overflow !== 1'b0 || load_ready !== 1'b1) begin
            bad++; $display("FAIL post_reset flags: got ovf=%b ready=%b want 0 1", overflow, load_ready);
        end
    endtask

    task automatic test_convert();
        do_load(16'd6765, "load6765");
        check_scan("scan6765", S6, S7, S6, S5, S6, S7, S6, S5, 1'b0);
        do_load(16'd42, "load42");
        check_scan("scan42", S_BLANK, S_BLANK, S4, S2, S0, S0, S4, S2, 1'b0);
    endtask

    task automatic test_overflow();
        do_load(16'd10000, "load10000");
        check_scan("scan10000", S_DASH, S_DASH, S_DASH, S_DASH,
                   S_DASH, S_DASH, S_DASH, S_DASH, 1'b1);
        do_load(16'd65535, "load65535");
        check_scan("scan65535", S_DASH, S_DASH, S_DASH, S_DASH,
                   S_DASH, S_DASH, S_DASH, S_DASH, 1'b1);
        do_load(16'd9999, "load9999");
        check_scan("scan9999", S9, S9, S9, S9, S9, S9, S9, S9, 1'b0);
    endtask

    task automatic test_back_to_back();
        int acc [$];
        wait_ready("b2b");
        load_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin
            load_data = (acc.size() % 2 == 0) ? 16'd1 : 16'd2;
            if (load_ready) acc.push_back(c);
            step();
        end
        load_valid = 1'b0;
        total++;
        if (acc.size() != 3) begin
            bad++; $display("FAIL b2b accept_count: got %0d want 3", acc.size());
        end
        for (int i = 1; i < acc.size(); i++) begin
            total++;
            if (acc[i] - acc[i-1] != 18) begin
                bad++; $display("FAIL b2b spacing %0d: got %0d want 18", i, acc[i] - acc[i-1]);
            end
        end
        wait_ready("b2b_drain");
        check_scan("scan_b2b", S_BLANK, S_BLANK, S_BLANK, S1, S0, S0, S0, S1, 1'b0);
    endtask

    task automatic test_hold();
        int n = 0;
        wait_ready("hold");
        load_data  = 16'd123;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        step(); step(); step();
        hold = 1'b1;
        while (busy && n < 40) begin
            n++;
            step();
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL hold commit: got busy=%b want 0", busy);
        end
        check_scan("scan123_hold", S_BLANK, S1, S2, S3, S0, S1, S2, S3, 1'b0);
        total++;
        if (load_ready !== 1'b0) begin
            bad++; $display("FAIL hold ready: got %b want 0", load_ready);
        end
        hold = 1'b0;
        #1;
        total++;
        if (load_ready !== 1'b1) begin
            bad++; $display("FAIL hold_release ready: got %b want 1", load_ready);
        end
    endtask

    task automatic test_reset_mid_shift();
        wait_ready("rst_mid");
        load_data  = 16'd8888;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        step(); step(); step(); step(); step();
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL rst_mid busy_before: got %b want 1", busy);
        end
        reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || anode_n !== 4'b1111 || seg_n !== S_BLANK) begin
            bad++; $display("FAIL rst_mid async: got busy=%b anode=%b seg=%b want 0 1111 1111111",
                            busy, anode_n, seg_n);
        end
        step();
        reset = 1'b0;
        check_scan("scan_after_rst", S_BLANK, S_BLANK, S_BLANK, S0, S0, S0, S0, S0, 1'b0);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL rst_mid no_resume: got busy=%b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_overflow();
        test_back_to_back();
        test_hold();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised multiplexed seven-segment display driver for the FPGA top level. It accepts binary values from the processor-side write path through a valid/ready handshake and converts them to BCD with an iterative double-dabble engine. Digits are scanned across a common-anode display of configurable width, with optional leading-zero blanking, overflow indication and a freeze input. It succeeds the fixed 4-digit combinational-divide display logic.

## Interface
- NUM_DIGITS, 4, number of display digits (1..8)
- DATA_W, 16, binary input width (4..32)
- REFRESH_DIV, 262144, clk_100mhz cycles each digit is driven (≥2)
- BLANK_LEADING, 1, 1 = leading zeros shown blank; units digit always shown
- clk_100mhz  in  1  system clock
- reset  in  1  asynchronous, active-high
- load_valid  in  1  load_data is valid
- load_data  in  DATA_W  unsigned binary value to display
- load_ready  out  1  converter idle and not frozen
- hold  in  1  freeze the displayed value; no loads accepted
- busy  out  1  conversion in progress
- overflow  out  1  displayed value ≥ 10^NUM_DIGITS
- anode_n  out  NUM_DIGITS  digit enables, active-low; bit NUM_DIGITS-1 is the leftmost digit (MSD)
- seg_n  out  7  segments {a,b,c,d,e,f,g}, active-low

## Operation
- Handshake: a load is accepted on a clock edge with load_valid && load_ready. load_ready = (state==IDLE) && !hold. Data is captured on acceptance; it need not be held afterwards.
- FSM states:
  - IDLE: accept → SHIFT. Latch load_data into the shift register, clear the BCD register, and latch ovf_next = (load_data ≥ 10^NUM_DIGITS).
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,bin} left by 1. After DATA_W cycles → COMMIT.
  - COMMIT: copy BCD into the display register and ovf_next into overflow → IDLE.
- BCD register is NUM_DIGITS nibbles. Bits above it are discarded; the overflow flag covers that loss.
- Display content per scanned digit:
  - overflow=1: segment g only (dash) on all digits.
  - Otherwise, the decoded nibble: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100. Nibbles >9 are illegal and show 0000001.
  - Blanking, when BLANK_LEADING=1: any digit above the units digit whose nibble and all higher nibbles are 0 shows 1111111. Its anode is still driven.
- Scan: refresh counter counts 0..REFRESH_DIV-1. At terminal count the digit index decrements, wrapping 0 → NUM_DIGITS-1. Order is MSD first. Exactly one anode_n bit is low at any time outside reset.
- hold=1 during SHIFT does not abort the conversion; COMMIT still occurs. Only new acceptances are blocked.
- load_valid while not ready is ignored; nothing is queued.

## Timing
- Reset values:
  - Outputs: anode_n all 1, seg_n 1111111, load_ready 0 while reset is asserted, busy 0, overflow 0.
  - Internal: display register 0, digit index NUM_DIGITS-1, refresh counter 0, state IDLE.
- After reset: the first edge drives anode_n with only the MSD bit low. It shows blank if BLANK_LEADING, else 0.
- Latency: display register and overflow update on edge DATA_W+1 after the acceptance edge. busy is high for those DATA_W+1 cycles. load_ready returns high on the cycle after COMMIT (if hold=0).
- Sustained rate: one load per DATA_W+2 cycles.
- anode_n and seg_n are registered: one cycle from digit-index or display-register change to pins.
- Display register and segment content never change mid-digit except at COMMIT.
- Reset mid-conversion aborts immediately. All state returns to reset values and the partial result is discarded.

## Structure
- Shared package seg7_pkg:
  - SEG_* active-low segment constants (digits 0-9, BLANK, DASH).
  - Constant function pow10(n) for the overflow threshold.
  - FSM state typedef {IDLE, SHIFT, COMMIT}.
- One sub-module: bin2bcd_seq (double-dabble FSM with start/done). The top holds the handshake, scan counter, blanking and decoder.

## Test plan
Bench parameters: NUM_DIGITS=4, DATA_W=16, REFRESH_DIV=4.
- Reset release, no load → anode_n sequence 0111, 1011, 1101, 1110, each for 4 cycles. seg_n shows 1111111 ×3 then 0000001. overflow=0.
- Load 6765 → busy high 17 cycles. Display then scans 0100000, 0001111, 0100000, 0100100.
- Load 42 → digits blank, blank, 1001100, 0010010. With BLANK_LEADING=0, 0000001, 0000001, 1001100, 0010010.
- Load 10000 and 65535 → overflow=1, all digits show 1111110. Then load 9999 → overflow=0, all digits show 0000100.
- Back-to-back load_valid held high with alternating 1/2 → exactly one acceptance per 18 cycles, load_ready low in between.
- Set hold mid-conversion of 123 → 123 still commits, load_ready stays 0 until hold drops. Assert reset mid-SHIFT → display returns to 0 and no commit occurs.
